conv_encoder_k7: RTL and testbench

// - Rate-1/2, K=7 (CCSDS 171/133 octal) convolutional encoder in the TTC downlink chain.
// - Accepts framed bytes over valid/ready, serialises them MSB first at one bit per Bit_En strobe.
// - Drives Convolutional_Encoder_out_0 (G1) and Convolutional_Encoder_out_1 (G2) into the serial output mux stage.
// - The output mux stage applies the G2 inversion, so this block emits G2 uninverted.

---
 rtl/conv_encoder_k7_if.sv | 29 ++
 rtl/conv_encoder_k7.sv | 177 +++++++++++++++++
 tb/tb_conv_encoder_k7.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/conv_encoder_k7_if.sv
// conv_encoder_k7_if
//   Byte-stream handshake into the K=7 convolutional encoder.
//   Din        : input word, serialised MSB first by the encoder
//   Din_Valid  : Din is valid
//   Din_Last   : Din is the last byte of a frame
//   Din_Ready  : encoder holding register is empty; transfer on Valid & Ready
//   master = byte source, slave = encoder
interface conv_encoder_k7_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] Din;
   logic              Din_Valid;
   logic              Din_Last;
   logic              Din_Ready;

   modport master (
      output Din,
      output Din_Valid,
      output Din_Last,
      input  Din_Ready
   );

   modport slave (
      input  Din,
      input  Din_Valid,
      input  Din_Last,
      output Din_Ready
   );
endinterface

// File: rtl/conv_encoder_k7.sv
// conv_encoder_k7
//   Rate-1/2, K=7 (171/133 octal) convolutional encoder for the TTC downlink.
//   Bytes arrive over din_if, are serialised MSB first at one bit per Bit_En
//   strobe, and each bit produces a registered G1/G2 symbol pair. G2 is
//   emitted uninverted; the downstream mux applies the inversion.
// Ports
//   Clk                          system clock
//   Rst                          asynchronous reset, active low
//   Bit_En                       one-Clk strobe per encoded bit-pair period
//   din_if                       byte stream (Din, Din_Valid, Din_Last, Din_Ready)
//   Convolutional_Encoder_out_0  G1 symbol
//   Convolutional_Encoder_out_1  G2 symbol
//   Enc_Valid                    symbols are meaningful for the current bit period
//   Underrun                     1-Clk pulse when data ran out mid-frame
//   Busy                         FSM not idle
// Build option
//   CONV_TAIL_FLUSH_EN : append 6 zero tail bits after each Last byte so the
//                        encoder state is zero at every frame start. Without
//                        it the state carries across frames.
module conv_encoder_k7 #(
   parameter logic [6:0]  G1_POLY = 7'o171,
   parameter logic [6:0]  G2_POLY = 7'o133,
   parameter int unsigned DATA_W  = 8
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Bit_En,
   conv_encoder_k7_if.slave   din_if,
   output logic               Convolutional_Encoder_out_0,
   output logic               Convolutional_Encoder_out_1,
   output logic               Enc_Valid,
   output logic               Underrun,
   output logic               Busy
);

   localparam int unsigned TAIL_LEN = 6;
   localparam int unsigned CNT_MAX  = (DATA_W > TAIL_LEN) ? DATA_W : TAIL_LEN;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

`ifdef CONV_TAIL_FLUSH_EN
   typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t            state;
   logic              hold_full;
   logic              hold_last;
   logic [DATA_W-1:0] hold_data;
   logic [DATA_W-1:0] shifter;
   logic              shift_last;
   logic [CNT_W-1:0]  cnt;
   logic [5:0]        sr;
   logic              out0;
   logic              out1;
   logic              enc_valid;
   logic              underrun;

   logic              b;
   logic [6:0]        w;
   logic              last_bit;
   logic              take;
   logic              load;

   always_comb begin
      b        = 1'b0;
      if (state == SHIFT)
         b = shifter[DATA_W-1];
      w        = {b, sr};
      last_bit = (cnt == CNT_W'(1));
      take     = din_if.Din_Valid & ~hold_full;
      // Hold -> shifter: immediately from IDLE, or back-to-back on the last
      // bit of a non-Last byte so the symbol stream has no gap.
      load     = hold_full & ((state == IDLE) |
                              ((state == SHIFT) & Bit_En & last_bit & ~shift_last));
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= IDLE;
         hold_full  <= 1'b0;
         hold_last  <= 1'b0;
         hold_data  <= '0;
         shifter    <= '0;
         shift_last <= 1'b0;
         cnt        <= '0;
         sr         <= '0;
         out0       <= 1'b0;
         out1       <= 1'b0;
         enc_valid  <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         underrun <= 1'b0;

         if (load)
            hold_full <= 1'b0;
         if (take) begin
            hold_full <= 1'b1;
            hold_data <= din_if.Din;
            hold_last <= din_if.Din_Last;
         end

         case (state)
            IDLE: begin
               // First strobe after a run closes it out.
               if (Bit_En && enc_valid) begin
                  enc_valid <= 1'b0;
                  out0      <= 1'b0;
                  out1      <= 1'b0;
               end
               if (hold_full)
                  state <= SHIFT;
            end

            SHIFT: begin
               if (Bit_En) begin
                  out0      <= ^(w & G1_POLY);
                  out1      <= ^(w & G2_POLY);
                  enc_valid <= 1'b1;
                  sr        <= {b, sr[5:1]};
                  shifter   <= {shifter[DATA_W-2:0], 1'b0};
                  cnt       <= cnt - CNT_W'(1);
                  if (last_bit) begin
                     if (!shift_last) begin
                        if (!hold_full) begin
                           underrun <= 1'b1;
                           state    <= IDLE;
                        end
                     end else begin
`ifdef CONV_TAIL_FLUSH_EN
                        state <= TAIL;
                        cnt   <= CNT_W'(TAIL_LEN);
`else
                        state <= IDLE;
`endif
                     end
                  end
               end
            end

`ifdef CONV_TAIL_FLUSH_EN
            TAIL: begin
               if (Bit_En) begin
                  out0      <= ^(w & G1_POLY);
                  out1      <= ^(w & G2_POLY);
                  enc_valid <= 1'b1;
                  sr        <= {1'b0, sr[5:1]};
                  cnt       <= cnt - CNT_W'(1);
                  if (last_bit) begin
                     state <= IDLE;
                     sr    <= '0;
                  end
               end
            end
`endif

            default: state <= IDLE;
         endcase

         // Placed after the case so a reload overrides the shift/decrement
         // of the final bit of the previous byte.
         if (load) begin
            shifter    <= hold_data;
            shift_last <= hold_last;
            cnt        <= CNT_W'(DATA_W);
         end
      end
   end

   assign din_if.Din_Ready            = ~hold_full;
   assign Convolutional_Encoder_out_0 = out0;
   assign Convolutional_Encoder_out_1 = out1;
   assign Enc_Valid                   = enc_valid;
   assign Underrun                    = underrun;
   assign Busy                        = (state != IDLE);

endmodule

// File: tb/tb_conv_encoder_k7.sv
// tb_conv_encoder_k7
//   Directed bench for conv_encoder_k7. Symbol sequences are hand-derived
//   from the 171/133 generator taps; frames run in table order, so encoder
//   state carries from one entry to the next when tail flushing is off.
module tb_conv_encoder_k7;

   localparam int unsigned DATA_W = 8;
`ifdef CONV_TAIL_FLUSH_EN
   localparam int unsigned NP = 14;
`else
   localparam int unsigned NP = 8;
`endif

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   logic Bit_En = 1'b0;
   logic out0, out1, Enc_Valid, Underrun, Busy;

   conv_encoder_k7_if #(.DATA_W(DATA_W)) din_if ();

   conv_encoder_k7 #(
      .G1_POLY(7'o171),
      .G2_POLY(7'o133),
      .DATA_W (DATA_W)
   ) dut (
      .Clk                         (Clk),
      .Rst                         (Rst),
      .Bit_En                      (Bit_En),
      .din_if                      (din_if),
      .Convolutional_Encoder_out_0 (out0),
      .Convolutional_Encoder_out_1 (out1),
      .Enc_Valid                   (Enc_Valid),
      .Underrun                    (Underrun),
      .Busy                        (Busy)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0]  din;
      logic        last;
      int unsigned n;
      logic [13:0] e0;   // first symbol in bit 13
      logic [13:0] e1;
      logic        urun;
   } vec_t;

   vec_t vt[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Outputs are sampled on the falling edge after the strobed rising edge.
   task automatic strobe();
      @(negedge Clk) Bit_En = 1'b1;
      @(negedge Clk) Bit_En = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int unsigned t = 0;
      @(negedge Clk);
      while (!din_if.Din_Ready && t < 50) begin
         @(negedge Clk);
         t++;
      end
      check("send_ready", 32'(din_if.Din_Ready), 32'd1);
      din_if.Din       = d;
      din_if.Din_Last  = l;
      din_if.Din_Valid = 1'b1;
      @(negedge Clk);
      din_if.Din_Valid = 1'b0;
      din_if.Din_Last  = 1'b0;
   endtask

   task automatic close_run(input string tag);
      strobe();
      check({tag, "_close"}, {28'd0, out0, out1, Enc_Valid, Busy}, 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      send(v.din, v.last);
      repeat (2) @(negedge Clk);
      for (int i = 0; i < int'(v.n); i++) begin
         strobe();
         check($sformatf("%s_o0_%0d", tag, i), 32'(out0), 32'(v.e0[13-i]));
         check($sformatf("%s_o1_%0d", tag, i), 32'(out1), 32'(v.e1[13-i]));
         check($sformatf("%s_ev_%0d", tag, i), 32'(Enc_Valid), 32'd1);
         check($sformatf("%s_busy_%0d", tag, i), 32'(Busy), 32'(i < int'(v.n) - 1));
         check($sformatf("%s_ur_%0d", tag, i), 32'(Underrun),
               32'(v.urun && (i == int'(v.n) - 1)));
      end
      @(negedge Clk);
      check({tag, "_ur_pulse_end"}, 32'(Underrun), 32'd0);
      close_run(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'h80, 1'b1, NP, 14'b11110010000000, 14'b10110110000000, 1'b0};
      vt[1] = '{8'h01, 1'b1, NP, 14'b00000001111001, 14'b00000001011011, 1'b0};
`ifdef CONV_TAIL_FLUSH_EN
      vt[2] = '{8'h00, 1'b1, NP, 14'b00000000000000, 14'b00000000000000, 1'b0};
`else
      vt[2] = '{8'h00, 1'b1, NP, 14'b11100100000000, 14'b01101100000000, 1'b0};
`endif
      vt[3] = '{8'hFF, 1'b0, 8,  14'b10100011000000, 14'b11011011000000, 1'b1};
      vt[4] = '{8'h00, 1'b1, NP, 14'b01011100000000, 14'b00100100000000, 1'b0};

      din_if.Din       = '0;
      din_if.Din_Valid = 1'b0;
      din_if.Din_Last  = 1'b0;

      // Reset state
      repeat (3) @(negedge Clk);
      check("in_reset", {26'd0, out0, out1, Enc_Valid, Busy, Underrun, din_if.Din_Ready}, 32'd1);
      Rst = 1'b1;
      @(negedge Clk);
      check("after_reset", {26'd0, out0, out1, Enc_Valid, Busy, Underrun, din_if.Din_Ready}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         strobe();
         check($sformatf("idle_strobe_%0d", i),
               {26'd0, out0, out1, Enc_Valid, Busy, Underrun, din_if.Din_Ready}, 32'd1);
      end

      // Single-byte frames, underrun, and state carry after underrun
      run_vec(vt[0], "imp80");
      run_vec(vt[1], "imp01");
      run_vec(vt[2], "cont00");
      run_vec(vt[3], "urunFF");
      run_vec(vt[4], "afterU");

      // Two back-to-back bytes: no Enc_Valid gap across the reload
      send(8'h00, 1'b0);
      send(8'h00, 1'b1);
      repeat (2) @(negedge Clk);
      for (int i = 0; i < int'(NP) + 8; i++) begin
         strobe();
         check($sformatf("pair_sym_%0d", i), {30'd0, out0, out1}, 32'd0);
         check($sformatf("pair_ev_%0d", i), 32'(Enc_Valid), 32'd1);
         check($sformatf("pair_busy_%0d", i), 32'(Busy), 32'(i < int'(NP) + 7));
      end
      close_run("pair");

      // Reset mid-frame with a second byte waiting in the holding register
      send(8'hA5, 1'b1);
      send(8'h5A, 1'b0);
      repeat (2) @(negedge Clk);
      strobe();
      check("abort_b0", {30'd0, out0, out1}, 32'd3);
      strobe();
      check("abort_b1", {30'd0, out0, out1}, 32'd2);
      strobe();
      check("abort_b2", {30'd0, out0, out1}, 32'd0);
      check("abort_pre", {29'd0, Enc_Valid, Busy, din_if.Din_Ready}, 32'd6);
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      check("abort_now", {26'd0, out0, out1, Enc_Valid, Busy, Underrun, din_if.Din_Ready}, 32'd1);
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         strobe();
         check($sformatf("abort_idle_%0d", i),
               {26'd0, out0, out1, Enc_Valid, Busy, Underrun, din_if.Din_Ready}, 32'd1);
      end
      run_vec(vt[0], "postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
